sample_frequency_detector: RTL
==============================

Name: sample_frequency_detector

Overview:
- Inverse of the waveform generators: consumes an 8-bit unsigned sample stream at the 32 kHz sample clock and recovers the fundamental frequency in Hz.
- Output uses the same 14-bit encoding the generators accept as a frequency command.
- Sits on the audio path after the mixer/generators. Used for self-test and for closed-loop tuning.
- Method: counts samples over N rising midpoint crossings with hysteresis, then divides sequentially.

Parameters:
- SAMPLE_RATE_HZ, 32000: samples per second; numerator constant.
- PERIODS_PER_MEASURE, 4: rising crossings per measurement window (N); power of two, 1..8.
- HYSTERESIS, 16: crossing threshold offset from midpoint 128.
- TIMEOUT_SAMPLES, 640: valid samples with no rising crossing before lock is lost (below 50 Hz).

Ports:
- CLK_32KHz  input  1  sample clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- inputSample  input  8  unsigned sample; 0..255, midpoint 128.
- sampleValid  input  1  qualifies inputSample; tie high for one sample per clock.
- detectedFrequency  output  14  last measured frequency, Hz; 0 when unlocked.
- frequencyValid  output  1  one-cycle pulse when detectedFrequency updates.
- locked  output  1  high while a valid measurement is held.
- crossingPulse  output  1  one-cycle pulse on each qualified rising crossing.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0.
  - State SEEK; armed=0; all counters 0; divider idle.
  - Reset mid-division aborts the division with no frequencyValid pulse.
- Crossing detector. Only cycles with sampleValid=1 have any effect.
  - armed<=1 when inputSample <= 128-HYSTERESIS.
  - Rising crossing when armed=1 and inputSample >= 128+HYSTERESIS. On that cycle armed<=0 and crossingPulse=1, registered (asserted the cycle after the sample).
  - A sample between the two thresholds changes nothing.
- State machine:
  - SEEK: windowCount=0, crossCount=0. The first crossing moves to MEASURE; windowCount starts counting from the next valid sample.
  - MEASURE: windowCount+1 per valid sample, saturating at 12 bits.
  - MEASURE, each crossing: crossCount+1. When crossCount reaches PERIODS_PER_MEASURE:
    - the window closes; windowCount (samples in window) is offered to the divider;
    - windowCount<=0 and crossCount<=0; that crossing starts the next window.
  - Timeout, in any state: sinceCrossing counts valid samples since the last crossing. When it reaches TIMEOUT_SAMPLES:
    - go to SEEK; locked<=0; detectedFrequency<=0; abort the divider;
    - frequencyValid pulses once only if locked was 1 (reports the drop to 0).
- Divider:
  - Computes quotient = (SAMPLE_RATE_HZ*PERIODS_PER_MEASURE) / windowCount.
  - Numerator 18 bits, denominator 12 bits, restoring, 1 bit per cycle.
  - Latency: 1 load cycle + 18 iterations. frequencyValid pulses 19 cycles after the closing crossing sample.
  - Quotient above 16383 saturates to 16383.
  - windowCount=0 is impossible by construction; if it occurs, result is 16383.
  - If the divider is busy when a window closes, the new window is dropped (no queue); counting continues normally.
- Result: on completion, detectedFrequency<=quotient[13:0], frequencyValid=1, locked<=1.
- Simultaneous events:
  - Timeout and crossing in the same cycle: the crossing wins and sinceCrossing clears.
  - Divider completion in the same cycle as a timeout: the timeout wins; the result is discarded.
- Frequency changes take effect at the next window boundary; no averaging across windows.

Optional Feature:
- Macro FREQDET_ROUNDING_EN.
  - Defined: numerator += windowCount>>1 before division; quotient rounds to nearest.
  - Undefined: quotient truncates.
- Latency is identical in both builds.

Decomposition:
- Package musicbox_audio_pkg:
  - constants SAMPLE_MIDPOINT=128, SAMPLE_W=8, FREQ_W=14, FREQ_MAX=16383;
  - typedef freqdet_state_t {SEEK, MEASURE}.
- Sub-module seq_divider: start/busy/done handshake, parameterised numerator and denominator widths, synchronous reset, abort input.

Test Plan:
- 1000 Hz triangle, 32 samples/period, sampleValid=1:
  - first frequencyValid 19 cycles after the 5th crossing;
  - detectedFrequency=1000, locked=1.
- 250 Hz triangle: windowCount=512 -> 250; subsequent windows repeat 250 every 512 cycles.
- 3000 Hz triangle, non-integer period, windowCount alternating 42/43:
  - truncating build: 3047/2976;
  - FREQDET_ROUNDING_EN build: 3048/2977.
- Noise ±10 around 128 for 700 samples after lock:
  - no crossingPulse;
  - at sample 640: locked=0, detectedFrequency=0, single frequencyValid.
- 8000 Hz pattern (0,128,255,128 repeating), sampleValid=1:
  - windowCount=16 closes while divider busy; alternate windows dropped;
  - results=8000 only.
- Assert reset during division at 1000 Hz:
  - all outputs 0 next cycle; no frequencyValid;
  - relock after reset release produces 1000.

Source files
------------

// File: rtl/musicbox_audio_pkg.sv
// Shared constants and types for the musicbox audio-path blocks.
// Used by sample_frequency_detector (optional build macro: FREQDET_ROUNDING_EN).
package musicbox_audio_pkg;
  localparam int SAMPLE_MIDPOINT = 128;
  localparam int SAMPLE_W        = 8;
  localparam int FREQ_W          = 14;
  localparam int FREQ_MAX        = 16383;

  typedef enum logic {
    SEEK    = 1'b0,
    MEASURE = 1'b1
  } freqdet_state_t;

  // Clamp a raw quotient to the generator frequency-command range.
  function automatic logic [FREQ_W-1:0] saturate_freq(input logic [31:0] q);
    logic [FREQ_W-1:0] sat;
    sat = (q > 32'(FREQ_MAX)) ? FREQ_W'(FREQ_MAX) : q[FREQ_W-1:0];
    return sat;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, with abort.
// A zero denominator yields an all-ones quotient.
module seq_divider #(
  parameter int NUM_W = 18,
  parameter int DEN_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quotient
);
  localparam int CNT_W = $clog2(NUM_W + 1);

  // Handshake: i_start is taken only while o_busy=0 (operands sampled that
  // edge); o_done is a one-cycle pulse during the final iteration, and
  // o_quotient is valid only in that cycle. i_abort beats everything.
  logic [NUM_W-1:0] r_quot;
  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;

  logic [DEN_W:0]   w_trial;
  logic [DEN_W:0]   w_diff;
  logic             w_fits;
  logic [NUM_W-1:0] w_quot_next;

  always_comb begin
    w_trial     = {r_rem, r_quot[NUM_W-1]};
    w_fits      = (w_trial >= {1'b0, r_den});
    w_diff      = w_trial - {1'b0, r_den};
    w_quot_next = {r_quot[NUM_W-2:0], w_fits};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_den   <= '0;
    end else if (i_start && !r_busy) begin
      r_busy  <= 1'b1;
      r_count <= CNT_W'(NUM_W);
      r_quot  <= i_num;
      r_rem   <= '0;
      r_den   <= i_den;
    end else if (r_busy) begin
      r_quot  <= w_quot_next;
      r_rem   <= DEN_W'(w_fits ? w_diff : w_trial);
      r_count <= r_count - CNT_W'(1);
      if (r_count == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_count == CNT_W'(1)) && !i_abort;
  assign o_quotient = w_quot_next;
endmodule

// File: rtl/sample_frequency_detector.sv
// Recovers the fundamental frequency of an 8-bit sample stream by timing N
// rising midpoint crossings. Build macro FREQDET_ROUNDING_EN rounds the quotient.
module sample_frequency_detector
  import musicbox_audio_pkg::*;
#(
  parameter int SAMPLE_RATE_HZ      = 32000,
  parameter int PERIODS_PER_MEASURE = 4,
  parameter int HYSTERESIS          = 16,
  parameter int TIMEOUT_SAMPLES     = 640
) (
  input  logic                CLK_32KHz,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] inputSample,
  input  logic                sampleValid,
  output logic [FREQ_W-1:0]   detectedFrequency,
  output logic                frequencyValid,
  output logic                locked,
  output logic                crossingPulse,
  output freqdet_state_t      o_dbg_state
);
  localparam int NUM_W = 18;
  localparam int DEN_W = 12;
  localparam int CNT_W = $clog2(PERIODS_PER_MEASURE + 1);
  localparam int TO_W  = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [SAMPLE_W-1:0] ARM_LVL   = SAMPLE_W'(SAMPLE_MIDPOINT - HYSTERESIS);
  localparam logic [SAMPLE_W-1:0] CROSS_LVL = SAMPLE_W'(SAMPLE_MIDPOINT + HYSTERESIS);
  localparam logic [NUM_W-1:0]    NUMERATOR = NUM_W'(SAMPLE_RATE_HZ * PERIODS_PER_MEASURE);

  freqdet_state_t   r_state, w_state_next;
  logic [DEN_W-1:0] r_window, w_window_next, w_window_inc;
  logic [CNT_W-1:0] r_cross_cnt, w_cross_cnt_next;
  logic [TO_W-1:0]  r_since;
  logic             r_armed;
  logic             r_cross_pulse;
  logic [FREQ_W-1:0] r_freq;
  logic             r_freq_valid;
  logic             r_locked;

  logic             w_cross;
  logic             w_close;
  logic             w_timeout;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [NUM_W-1:0] w_div_num;
  logic [NUM_W-1:0] w_div_quot;

  always_comb begin
    w_cross      = sampleValid && r_armed && (inputSample >= CROSS_LVL);
    w_window_inc = (r_window == '1) ? r_window : r_window + DEN_W'(1);
    w_close      = (r_state == MEASURE) && w_cross &&
                   (r_cross_cnt == CNT_W'(PERIODS_PER_MEASURE - 1));
    w_timeout    = sampleValid && !w_cross && (r_since >= TO_W'(TIMEOUT_SAMPLES - 1));
    w_div_start  = w_close && !w_div_busy;
  end

  // The closing crossing sample belongs to the window it closes.
`ifdef FREQDET_ROUNDING_EN
  assign w_div_num = NUMERATOR + NUM_W'(w_window_inc >> 1);
`else
  assign w_div_num = NUMERATOR;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_window_next    = r_window;
    w_cross_cnt_next = r_cross_cnt;
    case (r_state)
      SEEK: begin
        w_window_next    = '0;
        w_cross_cnt_next = '0;
        if (w_cross) w_state_next = MEASURE;
      end
      MEASURE: begin
        if (sampleValid) w_window_next = w_window_inc;
        if (w_close) begin
          w_window_next    = '0;
          w_cross_cnt_next = '0;
        end else if (w_cross) begin
          w_cross_cnt_next = r_cross_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = SEEK;
    endcase
    if (w_timeout) begin
      w_state_next     = SEEK;
      w_window_next    = '0;
      w_cross_cnt_next = '0;
    end
  end

  always_ff @(posedge CLK_32KHz) begin
    if (reset) begin
      r_state     <= SEEK;
      r_window    <= '0;
      r_cross_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_window    <= w_window_next;
      r_cross_cnt <= w_cross_cnt_next;
    end
  end

  always_ff @(posedge CLK_32KHz) begin
    if (reset) begin
      r_armed       <= 1'b0;
      r_cross_pulse <= 1'b0;
      r_since       <= '0;
      r_freq        <= '0;
      r_freq_valid  <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_cross_pulse <= w_cross;
      if (w_cross) r_armed <= 1'b0;
      else if (sampleValid && (inputSample <= ARM_LVL)) r_armed <= 1'b1;
      if (w_cross) r_since <= '0;
      else if (sampleValid && (r_since != TO_W'(TIMEOUT_SAMPLES))) r_since <= r_since + TO_W'(1);
      // A timeout discards any result finishing in the same cycle.
      r_freq_valid <= 1'b0;
      if (w_timeout) begin
        r_locked     <= 1'b0;
        r_freq       <= '0;
        r_freq_valid <= r_locked;
      end else if (w_div_done) begin
        r_freq       <= saturate_freq(32'(w_div_quot));
        r_freq_valid <= 1'b1;
        r_locked     <= 1'b1;
      end
    end
  end

  seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .i_clk      (CLK_32KHz),
    .i_rst      (reset),
    .i_start    (w_div_start),
    .i_abort    (w_timeout),
    .i_num      (w_div_num),
    .i_den      (w_window_inc),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_div_quot)
  );

  assign detectedFrequency = r_freq;
  assign frequencyValid    = r_freq_valid;
  assign locked            = r_locked;
  assign crossingPulse     = r_cross_pulse;
  assign o_dbg_state       = r_state;
endmodule
